// File: rtl/if_fetch_unit.sv
// Instruction fetch: sequential PC generation, one request in flight, DEPTH-entry {pc, inst} buffer.
// Redirects flush the buffer; a stale in-flight response is dropped via the discard flag.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          outstanding;
   logic          discard;
   logic [31:0]   fifo_pc   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [CW-1:0] slots;
   logic          req_fire;
   logic          rsp_fire;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_target;

   // Buffer slots reserved by the in-flight request keep a push from ever hitting a full FIFO.
   assign slots           = count + CW'(outstanding);
   assign imem_req_valid  = reset && (!outstanding || imem_rsp_valid) && (slots < CW'(DEPTH));
   assign imem_req_addr   = fetch_pc;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign rsp_fire        = imem_rsp_valid && outstanding;
   assign push            = rsp_fire && !discard && !redirect_valid;
   assign inst_valid      = (count != '0);
   assign pop             = inst_valid && inst_ready && !redirect_valid;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign inst_pc   = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
   assign inst_data = inst_valid ? fifo_data[rd_ptr] : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         req_pc      <= RESET_PC;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else begin
         if (redirect_valid)
            fetch_pc <= redirect_target;
         else if (req_fire)
            fetch_pc <= fetch_pc + 32'd4;

         if (req_fire)
            req_pc <= fetch_pc;

         if (req_fire)
            outstanding <= 1'b1;
         else if (rsp_fire)
            outstanding <= 1'b0;

         // A request left unanswered by the redirect cycle belongs to the old path.
         if (redirect_valid)
            discard <= req_fire || (outstanding && !imem_rsp_valid);
         else if (rsp_fire && discard)
            discard <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= req_pc;
         fifo_data[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-programmable memory, queue-based reference model, directed scenarios.
module tb_if_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // memory environment
   int          mem_lat = 1;
   logic [31:0] pend_addr [$];
   int          pend_cnt  [$];

   // reference model
   logic [31:0] m_fetch_pc;
   logic [31:0] m_req_pc;
   int          m_out;
   logic        m_disc;
   logic [63:0] m_q [$];

   // observation logs
   logic [31:0] fired_q    [$];
   logic [31:0] pop_pc_q   [$];
   logic [31:0] pop_data_q [$];
   int          pop_cyc_q  [$];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      fired_q.delete();
      pop_pc_q.delete();
      pop_data_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic model_reset();
      m_fetch_pc = RESET_PC;
      m_req_pc   = RESET_PC;
      m_out      = 0;
      m_disc     = 1'b0;
      m_q.delete();
   endtask

   // Called just after a rising edge: retire the delivered response, accept a new request, age the rest.
   task automatic mem_advance(input logic fire, input logic [31:0] addr);
      if (imem_rsp_valid && pend_addr.size() > 0) begin
         void'(pend_addr.pop_front());
         void'(pend_cnt.pop_front());
      end
      if (fire) begin
         pend_addr.push_back(addr);
         pend_cnt.push_back(mem_lat);
      end
      foreach (pend_cnt[i])
         if (pend_cnt[i] > 0) pend_cnt[i]--;
      if (pend_addr.size() > 0 && pend_cnt[0] == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memfn(pend_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic cycle();
      logic        e_req;
      logic        fire;
      logic        rspf;
      logic        dut_fire;
      logic [31:0] dut_addr;
      logic [31:0] old_pc;
      @(negedge clk);
      cyc++;
      e_req = ((m_out == 0) || imem_rsp_valid) && ((m_q.size() + m_out) < DEPTH);
      chk("req_valid", imem_req_valid, e_req);
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("inst_valid", inst_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("inst_pc", inst_pc, m_q[0][63:32]);
         chk("inst_data", inst_data, m_q[0][31:0]);
      end
      dut_fire = imem_req_valid && imem_req_ready;
      dut_addr = imem_req_addr;
      if (dut_fire) fired_q.push_back(dut_addr);
      if (inst_valid && inst_ready && !redirect_valid) begin
         pop_pc_q.push_back(inst_pc);
         pop_data_q.push_back(inst_data);
         pop_cyc_q.push_back(cyc);
      end
      fire   = e_req && imem_req_ready;
      rspf   = imem_rsp_valid && (m_out != 0);
      old_pc = m_fetch_pc;
      if (redirect_valid) begin
         m_q.delete();
         m_disc     = fire || ((m_out != 0) && !imem_rsp_valid);
         m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
         if (rspf) begin
            if (m_disc) m_disc = 1'b0;
            else        m_q.push_back({m_req_pc, imem_rsp_data});
         end
         if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (fire) begin
         m_req_pc = old_pc;
         m_out    = 1;
      end else if (rspf) begin
         m_out = 0;
      end
      @(posedge clk);
      #1;
      mem_advance(dut_fire, dut_addr);
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pend_addr.delete();
      pend_cnt.delete();
      #1;
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_inst_data", inst_data, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_logs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      #2;

      // 1: streaming with single-cycle memory
      mem_lat = 1;
      do_reset();
      repeat (6) cycle();
      chk("t1_fire0", at(fired_q, 0), 32'h0);
      chk("t1_fire1", at(fired_q, 1), 32'h4);
      chk("t1_fire2", at(fired_q, 2), 32'h8);
      chk("t1_fire3", at(fired_q, 3), 32'hC);
      chk("t1_pop0", at(pop_pc_q, 0), 32'h0);
      chk("t1_pop1", at(pop_pc_q, 1), 32'h4);
      chk("t1_pop2", at(pop_pc_q, 2), 32'h8);
      chk("t1_data1", at(pop_data_q, 1), 32'h0004_FFFB ^ 32'h1357_9BDF);
      chk("t1_nogap", (pop_cyc_q.size() >= 3) ? pop_cyc_q[2] - pop_cyc_q[0] : -1, 2);

      // 2: decode stalled fills DEPTH entries, then drains in order
      do_reset();
      inst_ready = 1'b0;
      repeat (8) cycle();
      chk("t2_full_req_valid", imem_req_valid, 0);
      chk("t2_full_addr", imem_req_addr, 32'h10);
      chk("t2_full_inst_valid", inst_valid, 1);
      clear_logs();
      inst_ready = 1'b1;
      repeat (6) cycle();
      chk("t2_pop0", at(pop_pc_q, 0), 32'h0);
      chk("t2_pop1", at(pop_pc_q, 1), 32'h4);
      chk("t2_pop2", at(pop_pc_q, 2), 32'h8);
      chk("t2_pop3", at(pop_pc_q, 3), 32'hC);
      chk("t2_data3", at(pop_data_q, 3), memfn(32'hC));
      chk("t2_resume", at(fired_q, 0), 32'h10);

      // 3: redirect with two buffered and one slow request in flight
      do_reset();
      inst_ready = 1'b0;
      mem_lat = 1;
      cycle();
      cycle();
      mem_lat = 3;
      cycle();
      chk("t3_pre_inst_valid", inst_valid, 1);
      clear_logs();
      mem_lat        = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      cycle();
      redirect_valid = 1'b0;
      chk("t3_flushed", inst_valid, 0);
      inst_ready = 1'b1;
      repeat (8) cycle();
      chk("t3_fire0", at(fired_q, 0), 32'h100);
      chk("t3_pop0", at(pop_pc_q, 0), 32'h100);
      chk("t3_data0", at(pop_data_q, 0), memfn(32'h100));

      // 4: redirect coinciding with a response and a pop
      do_reset();
      inst_ready = 1'b1;
      mem_lat = 1;
      cycle();
      cycle();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      cycle();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      chk("t4_flushed", inst_valid, 0);
      clear_logs();
      repeat (5) cycle();
      chk("t4_fire0", at(fired_q, 0), 32'h200);
      chk("t4_pop0", at(pop_pc_q, 0), 32'h200);

      // 5: redirect to the top of the address space wraps to zero
      do_reset();
      cycle();
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      clear_logs();
      repeat (6) cycle();
      chk("t5_fire0", at(fired_q, 0), 32'hFFFF_FFFC);
      chk("t5_fire1", at(fired_q, 1), 32'h0);
      chk("t5_pop0", at(pop_pc_q, 0), 32'hFFFF_FFFC);
      chk("t5_pop1", at(pop_pc_q, 1), 32'h0);

      // 6: reset mid-stream with three buffered and one outstanding
      do_reset();
      inst_ready = 1'b0;
      mem_lat = 1;
      repeat (3) cycle();
      mem_lat = 5;
      repeat (2) cycle();
      chk("t6_pre_inst_valid", inst_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_inst_valid", inst_valid, 0);
      chk("t6_async_req_valid", imem_req_valid, 0);
      model_reset();
      @(posedge clk);
      #1;
      mem_advance(1'b0, 32'h0);
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 10 && pend_addr.size() > 0; i++) cycle();
      chk("t6_late_rsp_drained", pend_addr.size(), 0);
      chk("t6_first_addr", imem_req_addr, RESET_PC);
      chk("t6_inst_valid", inst_valid, 0);
      clear_logs();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      repeat (4) cycle();
      chk("t6_fire0", at(fired_q, 0), RESET_PC);
      chk("t6_pop0", at(pop_pc_q, 0), RESET_PC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the RISCV decode/execute datapath.
- Generates sequential PCs from RESET_PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned {pc, instruction} pairs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid. In order; at most one per accepted request; latency ≥1 cycle.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; flush and restart fetch.
- redirect_pc  in  32  new fetch PC. Bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.

Behaviour:
- State:
  - fetch_pc[31:0]
  - FIFO: storage, rd/wr pointers, count 0..DEPTH
  - outstanding: 0/1; at most one request in flight
  - discard: 0/1; drop the next response
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, count=0, outstanding=0, discard=0. Outputs inst_valid=0, imem_req_valid=0, inst_data=0, inst_pc=0.
- Request issue:
  - slots = count + outstanding.
  - imem_req_valid = (!outstanding || imem_rsp_valid) && slots < DEPTH.
  - imem_req_addr = fetch_pc.
  - Fire = valid & ready. On fire: fetch_pc <= fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), outstanding <= 1.
  - Request/response overlap in the same cycle is allowed. This sustains 1 instr/cycle with single-cycle memory.
- Response:
  - imem_rsp_valid is honoured only while outstanding=1 (otherwise ignored).
  - If discard=0: push {fetch address of that request, data}, the request PC being held in an internal register.
  - If discard=1: drop the response and clear discard.
  - outstanding clears unless a new request fires in the same cycle.
- Output side:
  - inst_valid = (count != 0); inst_data/inst_pc come from the head.
  - Pop on inst_valid & inst_ready.
  - A simultaneous push and pop keeps count unchanged. A push when full cannot occur because the slots check prevents it.
  - A pop when empty has no effect.
- Redirect (highest priority, single cycle):
  - count <= 0, pointers <= 0; any same-cycle pop or push is cancelled.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A request firing in the redirect cycle, or an outstanding request whose response does not arrive in that cycle, sets discard=1.
  - A response arriving in the redirect cycle is dropped and leaves discard=0.
  - Back-to-back redirects: the last one wins. discard never exceeds 1 because outstanding ≤1.
  - inst_valid goes low the cycle after redirect. The first new-path instruction appears ≥1 cycle after its response.
- Latency: request fire → response (N cycles) → inst_valid the cycle after the response (registered FIFO write).
- Reset asserted mid-operation: all state returns to reset values immediately. Pending responses after reset release are ignored because outstanding=0.

Test Plan:
1. Reset release, memory ready=1, latency 1, inst_ready=1. Required: addrs 0,4,8,C fire on consecutive cycles; inst_pc sequence 0,4,8 with matching data; no gaps after the first.
2. inst_ready=0, ready=1. Required: exactly DEPTH(4) instructions buffered, then imem_req_valid=0 and fetch_pc=0x10. Raise inst_ready: in-order drain 0,4,8,C, then fetching resumes at 0x10.
3. Redirect to 0x103 while 2 entries are buffered and one request is in flight (response 2 cycles later). Required: FIFO emptied; stale response dropped; next fired addr=0x100; first inst_pc=0x100.
4. Redirect in the same cycle as a response and a pop. Required: response not enqueued, discard stays 0, count=0; next request addr = redirect target.
5. redirect_pc=32'hFFFF_FFFC. Required: fetches FFFF_FFFC then 0000_0000.
6. Drive reset low mid-stream with 3 entries buffered and one outstanding. Required: inst_valid=0 and imem_req_valid=0 asynchronously. After release, the first addr is RESET_PC; a late response is ignored.
